if_prefetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the single-cycle datapath. It owns the program counter and issues word reads to instruction memory. Returned instructions are buffered in a small prefetch FIFO and handed to the datapath over a valid/ready handshake. A branch or jump redirect from the datapath (the branch-adder target, gated by Branch AND Zero) flushes the buffer and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/prefetch_fifo.sv | 70 +++++++
 rtl/if_prefetch.sv | 99 +++++++++
 tb/tb_if_prefetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and constants shared by the instruction-fetch path.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small circular buffer holding fetched {instruction, pc} pairs.
// The head entry is read straight out of the entry registers.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] entry_q [DEPTH];

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && !flush && wr_ptr_reg == PW'(gi)) begin
          entry_reg <= wdata;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = entry_q[rd_ptr_reg];
  assign count = count_reg;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && count_reg == CW'(DEPTH)));

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory read in flight
// and buffers returned words for the datapath; redirects flush and restart.
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t          state_reg, state_next;
  logic [31:0]           fpc_reg, fpc_next;
  logic [31:0]           req_pc_reg;
  logic [CW-1:0]         count;
  logic [CW:0]           resv;
  logic                  pop, push, fire;
  logic [2*INSTR_W-1:0]  fifo_wdata, fifo_rdata;
  logic                  redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign ins_valid = (count != '0);
  assign pop       = ins_valid & ins_ready & ~redirect;
  assign push      = (state_reg == WAIT) & imem_rvalid & ~redirect;

  // Slots already claimed: buffered entries plus the wanted in-flight word.
  assign resv = (CW+1)'(count) + (CW+1)'(state_reg == WAIT) - (CW+1)'(pop);

  // rst_n gating keeps the request low while the stage is held in reset.
  assign imem_req = rst_n & ~redirect
                  & ((state_reg == FETCH) | ((state_reg == WAIT) & imem_rvalid))
                  & (resv < (CW+1)'(DEPTH));
  assign imem_addr = fpc_reg;
  assign fire      = imem_req & imem_gnt;

  always_comb begin
    state_next = state_reg;
    fpc_next   = fpc_reg;
    if (redirect) begin
      fpc_next = {redirect_pc[31:2], 2'b00};
      unique case (state_reg)
        FETCH:      state_next = FETCH;
        WAIT, DROP: state_next = imem_rvalid ? FETCH : DROP;
        default:    state_next = FETCH;
      endcase
    end else if (fire) begin
      fpc_next   = fpc_reg + 32'(PC_STEP);
      state_next = WAIT;
    end else if (state_reg != FETCH && imem_rvalid) begin
      state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      fpc_reg    <= RESET_PC;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      fpc_reg   <= fpc_next;
      if (fire) req_pc_reg <= fpc_reg;
    end
  end

  assign fifo_wdata = {imem_rdata, req_pc_reg};

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign {ins_data, ins_pc} = fifo_rdata;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: random memory/consumer/redirect traffic scored against
// an in-order instruction-stream model, plus directed boundary scenarios.
module tb_if_prefetch;

  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        ins_valid, ins_ready;
  logic [31:0] ins_data, ins_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: after reset or a redirect the datapath must see the
  // consecutive words starting at the target, each paired with its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_next;

  function automatic void model_fill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: exp_next, data: memf(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = {pc[31:2], 2'b00};
    model_fill();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    model_restart(pc);
  endtask

  // Memory: one read in flight, response mem_lat extra cycles after the grant
  // (random 0..2 when negative); grant policy from gnt_mode.
  int          gnt_mode = 0;
  int          mem_lat  = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_rvalid) mem_busy = 1'b0;
      if (imem_req && imem_gnt) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
      end
      @(posedge clk);
      #1;
      imem_rvalid = mem_busy && (mem_wait == 0);
      if (mem_busy && mem_wait > 0) mem_wait--;
      imem_rdata = imem_rvalid ? memf(mem_addr) : $urandom;
      imem_gnt   = (gnt_mode == 0) ? 1'b1 :
                   (gnt_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
    end
  end

  // Monitor: every accepted instruction is popped from the model and compared.
  logic        redir_prev = 1'b0;
  logic [31:0] last_pc    = '0;
  logic        saw_wrap   = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        redir_prev = 1'b0;
      end else begin
        if (redir_prev) check("valid_after_redirect", 32'(ins_valid), 32'd0);
        if (ins_valid && ins_ready && !redirect) begin
          e = exp_q.pop_front();
          check("ins_pc", ins_pc, e.pc);
          check("ins_data", ins_data, e.data);
          if (last_pc == 32'hFFFF_FFFC && ins_pc == 32'h0) saw_wrap = 1'b1;
          last_pc = ins_pc;
          pops++;
          model_fill();
        end
        redir_prev = redirect;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, n, nv, p0;
    logic        found, stable;
    logic [31:0] a0;

    rst_n       = 1'b0;
    ins_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_restart(RESET_PC);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_data", ins_data, 32'd0);
    check("rst_ins_pc", ins_pc, 32'd0);

    // Stream: first valid in the 3rd cycle, then one per cycle
    step();
    rst_n = 1'b1;
    model_restart(RESET_PC);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ins_valid) begin
        k = i;
        break;
      end
      step();
    end
    check("first_valid_cycle", k, 32'd3);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      if (ins_valid) n++;
    end
    check("throughput", n, 32'd8);

    // Backpressure: buffer fills, request stops, head holds
    step();
    ins_ready = 1'b0;
    @(negedge clk);
    cycles(9);
    check("bp_imem_req", 32'(imem_req), 32'd0);
    check("bp_ins_valid", 32'(ins_valid), 32'd1);
    check("bp_head_pc", ins_pc, exp_q[0].pc);
    gnt_mode = 2;
    p0 = pops;
    step();
    ins_ready = 1'b1;
    @(negedge clk);
    cycles(5);
    check("bp_drained_count", pops - p0, DEPTH);
    check("bp_empty_after_drain", 32'(ins_valid), 32'd0);
    gnt_mode = 0;

    // Redirect while a wanted response is still outstanding
    step();
    mem_lat = 1;
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        break;
      end
      step();
      @(negedge clk);
    end
    check("wait_grant_seen", 32'(found), 32'd1);
    step();
    do_redirect(32'h0000_2002);
    @(negedge clk);
    check("wait_redirect_req", 32'(imem_req), 32'd0);
    step();
    mem_lat = 0;
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      step();
      @(negedge clk);
    end
    check("wait_new_req_seen", 32'(found), 32'd1);
    check("wait_new_addr", imem_addr, 32'h0000_2000);
    cycles(6);

    // Redirect in the same cycle as rvalid with a consumer ready
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      if (imem_req && imem_gnt && ins_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("coinc_setup", 32'(found), 32'd1);
    step();
    do_redirect(32'h0000_4447);
    @(negedge clk);
    check("coinc_redirect_req", 32'(imem_req), 32'd0);
    cycles(8);

    // Grant stall: address held, nothing pushed
    gnt_mode = 2;
    cycles(2);
    a0     = imem_addr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (!imem_req || imem_addr !== a0) stable = 1'b0;
    end
    check("stall_addr_stable", 32'(stable), 32'd1);
    check("stall_req_held", 32'(imem_req), 32'd1);
    check("stall_no_push", 32'(ins_valid), 32'd0);
    check("stall_addr", imem_addr, exp_q[0].pc);
    gnt_mode = 0;

    // PC wrap at the top of the address space
    step();
    do_redirect(32'hFFFF_FFFE);
    @(negedge clk);
    cycles(10);
    check("pc_wrap", 32'(saw_wrap), 32'd1);

    // Random traffic
    gnt_mode = 1;
    step();
    mem_lat = -1;
    @(negedge clk);
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      step();
      ins_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) do_redirect($urandom);
      @(negedge clk);
    end
    gnt_mode = 0;
    step();
    ins_ready = 1'b1;
    mem_lat   = 0;
    @(negedge clk);
    cycles(20);
    check("random_progress", 32'((pops - p0) > 100), 32'd1);

    // Async reset while WAIT with two buffered entries, then a stray rvalid
    step();
    do_redirect(32'h0000_3000);
    ins_ready = 1'b0;
    mem_lat   = 4;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 80 && n < 2; i++) begin
      if (imem_req && imem_gnt && imem_rvalid) n++;
      if (n < 2) begin
        step();
        @(negedge clk);
      end
    end
    check("areset_setup", n, 32'd2);
    gnt_mode = 2;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_ins_valid", 32'(ins_valid), 32'd0);
    check("areset_imem_req", 32'(imem_req), 32'd0);
    check("areset_imem_addr", imem_addr, RESET_PC);
    check("areset_ins_pc", ins_pc, 32'd0);
    check("areset_ins_data", ins_data, 32'd0);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    model_restart(RESET_PC);
    @(negedge clk);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (ins_valid) nv++;
      step();
      @(negedge clk);
    end
    check("stray_rvalid_ignored", nv, 32'd0);
    gnt_mode = 0;
    step();
    ins_ready = 1'b1;
    mem_lat   = 0;
    @(negedge clk);
    p0 = pops;
    cycles(15);
    check("post_reset_stream", 32'((pops - p0) >= 10), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
